// File: rtl/aes_inv_key_schedule_generator_if.sv
// Purpose : handshake/bus bundle between the inverse key schedule and its controller/consumer.
// Latency : none (wires only).
// Backpressure: round_key_ready from the consumer stalls the generator while round_key_valid=1.
// Signals : start/last_round_key (controller -> generator), round_key/round_idx/round_key_valid
//           (generator -> consumer), round_key_ready (consumer -> generator), busy/done (status).
// Modports: slave = the generator, master = the controller/consumer side driving it.
interface aes_inv_key_schedule_generator_if;
   logic         start;
   logic [127:0] last_round_key;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         round_key_valid;
   logic         round_key_ready;
   logic         busy;
   logic         done;

   modport slave (
      input  start,
      input  last_round_key,
      input  round_key_ready,
      output round_key,
      output round_idx,
      output round_key_valid,
      output busy,
      output done
   );

   modport master (
      output start,
      output last_round_key,
      output round_key_ready,
      input  round_key,
      input  round_idx,
      input  round_key_valid,
      input  busy,
      input  done
   );
endinterface

// File: rtl/aes_inv_key_schedule_generator.sv
// Purpose : inverse AES-128 key expansion; regenerates round keys 10..0 from the round-10 key,
//           one 32-bit word per cycle, presenting each 128-bit round key on a valid/ready port.
// Latency : start -> round 10 valid next cycle; accept -> next key valid 5 cycles later
//           (6 with AES_INV_KEY_SBOX_PIPE_EN defined, which registers the S-box output).
// Backpressure: a presented key is held unchanged until round_key_ready; no state changes meanwhile.
// Ports   : clk, rst_n (async active-low), bus (aes_inv_key_schedule_generator_if.slave):
//           start, last_round_key in; round_key, round_idx, round_key_valid, busy, done out;
//           round_key_ready in.
// Config  : `define AES_INV_KEY_SBOX_PIPE_EN to split word step 0 into S-box register + XOR cycles.
module aes_inv_key_schedule_generator #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic                              clk,
   input  logic                              rst_n,
   aes_inv_key_schedule_generator_if.slave   bus
);

   typedef struct packed {
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w2;
      logic [31:0] w3;
   } key_t;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PRESENT = 2'd1;
   localparam logic [1:0] S_GEN     = 2'd2;
`ifdef AES_INV_KEY_SBOX_PIPE_EN
   localparam logic [1:0] S_SUB     = 2'd3;
`endif

   // Forward AES S-box, one row of 16 bytes per entry, byte 0 in the MSBs.
   localparam logic [127:0] SBOX_ROW [16] = '{
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [127:0] row;
      row = SBOX_ROW[b[7:4]];
      // ~col == 15-col: byte 0 sits at bits [127:120]
      return row[{~b[3:0], 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   // Rcon walked backwards: inverse of xtime over GF(2^8).
   function automatic logic [7:0] rcon_prev(input logic [7:0] r);
      return r[0] ? (((r ^ 8'h1b) >> 1) | 8'h80) : (r >> 1);
   endfunction

   logic [1:0]  state;
   key_t        key_q;
   logic [3:0]  idx_q;
   logic [7:0]  rcon_q;
   logic [1:0]  step_q;
   logic        done_q;
   logic [31:0] sub_rot;
`ifdef AES_INV_KEY_SBOX_PIPE_EN
   logic [31:0] sub_q;
`endif

   // By step 0 the w3 register already holds the recovered w3, which is what SubWord needs.
   assign sub_rot = sub_word({key_q.w3[23:0], key_q.w3[31:24]});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         key_q  <= '0;
         idx_q  <= 4'd0;
         rcon_q <= 8'h36;
         step_q <= 2'd3;
         done_q <= 1'b0;
`ifdef AES_INV_KEY_SBOX_PIPE_EN
         sub_q  <= 32'h0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  key_q  <= bus.last_round_key;
                  idx_q  <= 4'(NUM_ROUNDS);
                  rcon_q <= 8'h36;
                  state  <= S_PRESENT;
               end
            end
            S_PRESENT: begin
               if (bus.round_key_ready) begin
                  if (idx_q == 4'd0) begin
                     state  <= S_IDLE;
                     done_q <= 1'b1;
                  end else begin
                     state  <= S_GEN;
                     step_q <= 2'd3;
                  end
               end
            end
            S_GEN: begin
               case (step_q)
                  2'd3: begin
                     key_q.w3 <= key_q.w3 ^ key_q.w2;
                     step_q   <= 2'd2;
                  end
                  2'd2: begin
                     key_q.w2 <= key_q.w2 ^ key_q.w1;
                     step_q   <= 2'd1;
                  end
                  2'd1: begin
                     key_q.w1 <= key_q.w1 ^ key_q.w0;
                     step_q   <= 2'd0;
                  end
                  default: begin
`ifdef AES_INV_KEY_SBOX_PIPE_EN
                     sub_q <= sub_rot;
                     state <= S_SUB;
`else
                     key_q.w0 <= key_q.w0 ^ sub_rot ^ {rcon_q, 24'h0};
                     idx_q    <= idx_q - 4'd1;
                     rcon_q   <= rcon_prev(rcon_q);
                     state    <= S_PRESENT;
`endif
                  end
               endcase
            end
`ifdef AES_INV_KEY_SBOX_PIPE_EN
            S_SUB: begin
               key_q.w0 <= key_q.w0 ^ sub_q ^ {rcon_q, 24'h0};
               idx_q    <= idx_q - 4'd1;
               rcon_q   <= rcon_prev(rcon_q);
               state    <= S_PRESENT;
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.round_key       = key_q;
   assign bus.round_idx       = idx_q;
   assign bus.round_key_valid = (state == S_PRESENT);
   assign bus.busy            = (state != S_IDLE);
   assign bus.done            = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule_generator.sv
// Purpose : scoreboard bench for aes_inv_key_schedule_generator using FIPS-197 key vectors.
// Latency : expected key cycles derived from 5 (or 6 with the S-box pipe) cycles per round.
// Backpressure: a random-ready run checks that presented keys hold while stalled.
module tb_aes_inv_key_schedule_generator;

`ifdef AES_INV_KEY_SBOX_PIPE_EN
   localparam int RND_CYC = 6;
`else
   localparam int RND_CYC = 5;
`endif

   // Round keys indexed by round number, from FIPS-197 C.1 and Appendix A.
   localparam logic [127:0] C1 [11] = '{
      128'h000102030405060708090a0b0c0d0e0f,
      128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
      128'hb692cf0b643dbdf1be9bc5006830b3fe,
      128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
      128'h47f7f7bc95353e03f96c32bcfd058dfd,
      128'h3caaa3e8a99f9deb50f3af57adf622aa,
      128'h5e390f7df7a69296a7553dc10aa31f6b,
      128'h14f9701ae35fe28c440adf4d4ea9c026,
      128'h47438735a41c65b9e016baf4aebf7ad2,
      128'h549932d1f08557681093ed9cbe2c974e,
      128'h13111d7fe3944a17f307a78b4d2b30c5
   };
   localparam logic [127:0] APP [11] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] key;
      int           cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   bit   rand_rdy = 1'b0;
   exp_t sb[$];
   int   dq[$];

   aes_inv_key_schedule_generator_if bus();

   aes_inv_key_schedule_generator #(.NUM_ROUNDS(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every accept, checks hold-under-stall and done timing.
   bit           hold_pending = 1'b0;
   logic [127:0] held_key;
   logic [3:0]   held_idx;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         hold_pending = 1'b0;
      end else begin
         if (hold_pending) begin
            chk("stall_valid", 128'(bus.round_key_valid), 128'(1));
            chk("stall_key", bus.round_key, held_key);
            chk("stall_idx", 128'(bus.round_idx), 128'(held_idx));
         end
         if (bus.round_key_valid && bus.round_key_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_key", 128'(bus.round_idx), 128'hffff);
            end else begin
               e = sb.pop_front();
               chk("round_idx", 128'(bus.round_idx), 128'(e.idx));
               chk("round_key", bus.round_key, e.key);
               if (e.cyc >= 0) chk("key_cycle", 128'(cyc), 128'(e.cyc));
            end
         end
         if (bus.done) begin
            if (dq.size() == 0) begin
               chk("unexpected_done", 128'(cyc), 128'hffff);
            end else begin
               int dc;
               dc = dq.pop_front();
               if (dc >= 0) chk("done_cycle", 128'(cyc), 128'(dc));
            end
         end
         hold_pending = bus.round_key_valid && !bus.round_key_ready;
         held_key     = bus.round_key;
         held_idx     = bus.round_idx;
      end
   end

   // Random ready driver for the backpressure run.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) bus.round_key_ready = 1'($urandom_range(0, 1));
      end
   end

   // Push expectations for a sequence whose start is sampled at the end of cycle t0.
   task automatic push_seq(input bit use_app, input int t0, input bit timed, input int nkeys);
      exp_t e;
      for (int k = 0; k < nkeys; k++) begin
         e.idx = 4'(10 - k);
         e.key = use_app ? APP[10 - k] : C1[10 - k];
         e.cyc = timed ? t0 + 1 + RND_CYC * k : -1;
         sb.push_back(e);
      end
      if (nkeys == 11) dq.push_back(timed ? t0 + 2 + RND_CYC * 10 : -1);
   endtask

   task automatic do_start(input bit use_app, input bit timed, input int nkeys, output int t0);
      @(posedge clk);
      #1;
      bus.last_round_key = use_app ? APP[10] : C1[10];
      bus.start = 1'b1;
      t0 = cyc;
      push_seq(use_app, t0, timed, nkeys);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic at_cycle(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((sb.size() != 0 || dq.size() != 0 || bus.busy) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      tests++;
      if (n >= budget) begin
         fails++;
         $display("FAIL drain_timeout: %0d keys and %0d done pulses outstanding after %0d cycles",
                  sb.size(), dq.size(), n);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_round_key"}, bus.round_key, 128'h0);
      chk({tag, "_round_idx"}, 128'(bus.round_idx), 128'h0);
      chk({tag, "_valid"}, 128'(bus.round_key_valid), 128'h0);
      chk({tag, "_busy"}, 128'(bus.busy), 128'h0);
      chk({tag, "_done"}, 128'(bus.done), 128'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int fin;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.last_round_key = '0;
      bus.round_key_ready = 1'b0;
      #12;
      chk_zero_outputs("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.round_key_ready = 1'b1;

      // FIPS-197 C.1 with ready held high: exact cycle timing checked.
      do_start(1'b0, 1'b1, 11, t0);
      drain(200);

      // Appendix A with random backpressure.
      rand_rdy = 1'b1;
      do_start(1'b1, 1'b0, 11, t0);
      drain(2000);
      rand_rdy = 1'b0;
      @(posedge clk);
      #1;
      bus.round_key_ready = 1'b1;

      // Starts while busy are ignored; start held over the final accept and done cycles
      // launches exactly one new sequence from the done cycle.
      do_start(1'b0, 1'b1, 11, t0);
      bus.last_round_key = APP[10];
      at_cycle(t0 + 3);
      bus.start = 1'b1;
      at_cycle(t0 + 4);
      bus.start = 1'b0;
      at_cycle(t0 + 20);
      bus.start = 1'b1;
      at_cycle(t0 + 21);
      bus.start = 1'b0;
      fin = t0 + 1 + RND_CYC * 10;
      at_cycle(fin);
      bus.start = 1'b1;
      push_seq(1'b1, fin + 1, 1'b1, 11);
      at_cycle(fin + 2);
      bus.start = 1'b0;
      drain(300);

      // Reset during generation of round 5: only rounds 10..6 are ever accepted.
      do_start(1'b0, 1'b1, 5, t0);
      at_cycle(t0 + 1 + RND_CYC * 4 + 2);
      rst_n = 1'b0;
      #1;
      chk_zero_outputs("midreset");
      chk("midreset_pending", 128'(sb.size()), 128'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_zero_outputs("held_reset");
      rst_n = 1'b1;
      do_start(1'b1, 1'b1, 11, t0);
      drain(200);

      repeat (3) @(posedge clk);
      #1;
      chk("final_sb_empty", 128'(sb.size()), 128'h0);
      chk("final_done_empty", 128'(dq.size()), 128'h0);
      chk("final_busy", 128'(bus.busy), 128'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
